// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_pkg
//  Purpose  : Shared types and constants for the sequential add/subtract unit.
//             Holds the control-FSM state type and the operation encoding
//             used on the 'sub' input.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rca_chunk.sv
`default_nettype none
// ============================================================================
//  Module   : rca_chunk
//  Purpose  : Combinational CHUNK-bit ripple-carry adder slice. Reused by the
//             sequential unit once per clock.
//  Ports    : a, b   [CHUNK-1:0]  in   slice operands
//             cin                 in   carry into bit 0
//             sum    [CHUNK-1:0]  out  slice sum
//             cout                out  carry out of the slice MSB
//             c_msb               out  carry into the slice MSB
//  Revision : 1.0 - initial release
// ============================================================================
module rca_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);
   import addsub_pkg::*;

   // w_c[i] is the carry into bit i; w_c[CHUNK] is the carry out.
   logic [CHUNK:0] w_c;

   assign w_c[0] = cin;

   genvar i;
   generate
      for (i = 0; i < CHUNK; i++) begin : g_fa
         assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
         assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
      end
   endgenerate

   assign cout  = w_c[CHUNK];
   assign c_msb = w_c[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/seq_addsub_unit.sv
`default_nettype none
// ============================================================================
//  Module   : seq_addsub_unit
//  Purpose  : Multi-cycle two's-complement adder/subtractor. Processes CHUNK
//             bits per clock through one reused ripple-carry slice, so an
//             operation takes N = WIDTH/CHUNK RUN cycles. Valid/ready
//             handshakes on both sides; reports carry, signed overflow, zero
//             and negative flags alongside the result.
//  Ports    : clk, rst_n                 in   clock, async active-low reset
//             start_valid / start_ready  in/out  operand handshake
//             op_a, op_b [WIDTH-1:0]     in   operands (sampled on accept)
//             sub                        in   0 = A+B, 1 = A-B
//             res_valid / res_ready      out/in  result handshake
//             result [WIDTH-1:0]         out  sum/difference mod 2^WIDTH
//             carry_out, overflow,
//             zero, negative             out  status flags
//  Revision : 1.0 - initial release
// ============================================================================
module seq_addsub_unit #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             sub,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);
   import addsub_pkg::*;

   localparam int c_n_slices = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
   localparam int c_cnt_w    = $clog2(c_n_slices) + 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n_slices - 1);

   generate
      if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("seq_addsub_unit: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;       // already inverted for subtraction
   logic               r_carry;
   logic [c_cnt_w-1:0] r_cnt;

   logic [CHUNK-1:0]   w_sum;
   logic               w_cout;
   logic               w_cmsb;
   logic [WIDTH-1:0]   w_next_acc; // accumulated result including this slice

   rca_chunk #(.CHUNK(CHUNK)) u_slice (
      .a     (r_a[CHUNK-1:0]),
      .b     (r_b[CHUNK-1:0]),
      .cin   (r_carry),
      .sum   (w_sum),
      .cout  (w_cout),
      .c_msb (w_cmsb)
   );

   // Slice sums enter from the MSB end, so after N slices the first one has
   // reached the bottom. With a single slice there is nothing to accumulate.
   generate
      if (c_n_slices == 1) begin : g_single
         assign w_next_acc = w_sum;
      end else begin : g_multi
         logic [WIDTH-CHUNK-1:0] r_acc;

         assign w_next_acc = {w_sum, r_acc};

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_acc <= '0;
            end else if (r_state == RUN) begin
               r_acc <= w_next_acc[WIDTH-1:CHUNK];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         start_ready <= 1'b0;
         res_valid   <= 1'b0;
         result      <= '0;
         carry_out   <= 1'b0;
         overflow    <= 1'b0;
         zero        <= 1'b0;
         negative    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_valid && start_ready) begin
                  r_a         <= op_a;
                  r_b         <= op_b ^ {WIDTH{sub}};
                  r_carry     <= (sub == OP_SUB);
                  r_cnt       <= '0;
                  start_ready <= 1'b0;
                  r_state     <= RUN;
               end else begin
                  start_ready <= 1'b1;
               end
            end

            RUN: begin
               r_a     <= r_a >> CHUNK;
               r_b     <= r_b >> CHUNK;
               r_carry <= w_cout;
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == c_last) begin
                  // Only the final slice carries the operand MSB, so its
                  // carries define the carry and signed-overflow flags.
                  result    <= w_next_acc;
                  carry_out <= w_cout;
                  overflow  <= w_cmsb ^ w_cout;
                  zero      <= (w_next_acc == '0);
                  negative  <= w_next_acc[WIDTH-1];
                  res_valid <= 1'b1;
                  r_state   <= DONE;
               end
            end

            DONE: begin
               if (res_ready) begin
                  res_valid   <= 1'b0;
                  start_ready <= 1'b1;
                  r_state     <= IDLE;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_addsub_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_addsub_unit
//  Purpose  : Self-checking bench for seq_addsub_unit. Three instances cover
//             WIDTH/CHUNK = 16/4, 16/16 and 8/1; results are compared with an
//             arithmetic reference model.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_addsub_unit;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        sv [3];
   logic        rr [3];
   logic        sb [3];
   logic [15:0] oa [3];
   logic [15:0] ob [3];
   logic        sr [3];
   logic        rv [3];
   logic        co [3];
   logic        ov [3];
   logic        zr [3];
   logic        ng [3];
   logic [15:0] res0;
   logic [15:0] res1;
   logic [7:0]  res2;

   int n_chk  = 0;
   int n_fail = 0;

   const int N_OF [3] = '{4, 1, 8};
   const int W_OF [3] = '{16, 16, 8};

   always #5 clk = ~clk;

   seq_addsub_unit #(.WIDTH(16), .CHUNK(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(sr[0]),
      .op_a(oa[0]), .op_b(ob[0]), .sub(sb[0]), .res_valid(rv[0]),
      .res_ready(rr[0]), .result(res0), .carry_out(co[0]), .overflow(ov[0]),
      .zero(zr[0]), .negative(ng[0]));

   seq_addsub_unit #(.WIDTH(16), .CHUNK(16)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(sr[1]),
      .op_a(oa[1]), .op_b(ob[1]), .sub(sb[1]), .res_valid(rv[1]),
      .res_ready(rr[1]), .result(res1), .carry_out(co[1]), .overflow(ov[1]),
      .zero(zr[1]), .negative(ng[1]));

   seq_addsub_unit #(.WIDTH(8), .CHUNK(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start_valid(sv[2]), .start_ready(sr[2]),
      .op_a(oa[2][7:0]), .op_b(ob[2][7:0]), .sub(sb[2]), .res_valid(rv[2]),
      .res_ready(rr[2]), .result(res2), .carry_out(co[2]), .overflow(ov[2]),
      .zero(zr[2]), .negative(ng[2]));

   function automatic logic [15:0] res_of(input int d);
      case (d)
         0:       return res0;
         1:       return res1;
         default: return {8'h00, res2};
      endcase
   endfunction

   function automatic logic [3:0] flags_of(input int d);
      return {co[d], ov[d], zr[d], ng[d]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on a w-bit word.
   function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic s, output logic [15:0] r, output logic [3:0] f);
      longint one, mask, ua, ub, full, sa, sb_, sres, lim;
      logic c, v, z, n;
      one  = 1;
      mask = (one << w) - 1;
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      full = s ? (ua + ((~ub) & mask) + 1) : (ua + ub);
      r    = 16'(full & mask);
      c    = ((full >> w) & 1) != 0;
      lim  = one << (w - 1);
      sa   = (ua >= lim) ? ua - (one << w) : ua;
      sb_  = (ub >= lim) ? ub - (one << w) : ub;
      sres = s ? (sa - sb_) : (sa + sb_);
      v    = (sres > lim - 1) || (sres < -lim);
      z    = (r == 16'h0);
      n    = r[w-1];
      f    = {c, v, z, n};
   endfunction

   task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input int hold, input string tag);
      logic [15:0] er;
      logic [3:0]  ef;
      int          lat;
      model(W_OF[d], a, b, s, er, ef);
      lat = 0;
      while (!sr[d] && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      chk({tag, " start_ready idle"}, 32'(sr[d]), 32'd1);
      @(negedge clk);
      oa[d] = a; ob[d] = b; sb[d] = s; sv[d] = 1'b1;
      @(posedge clk); #1;
      // Scramble inputs after the accept edge; they must have no effect.
      sv[d] = 1'b0; oa[d] = 16'($urandom); ob[d] = 16'($urandom); sb[d] = 1'($urandom);
      chk({tag, " start_ready busy"}, 32'(sr[d]), 32'd0);
      lat = 0;
      while (!rv[d] && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(N_OF[d]));
      chk({tag, " result"}, 32'(res_of(d)), 32'(er));
      chk({tag, " flags cvzn"}, 32'(flags_of(d)), 32'(ef));
      repeat (hold) begin
         @(negedge clk);
         sv[d] = ~sv[d]; oa[d] = 16'($urandom); ob[d] = 16'($urandom); sb[d] = 1'($urandom);
         @(posedge clk); #1;
         chk({tag, " hold valid/ready"}, {30'd0, rv[d], sr[d]}, 32'b10);
         chk({tag, " hold result+flags"}, {12'd0, flags_of(d), res_of(d)}, {12'd0, ef, er});
      end
      @(negedge clk);
      sv[d] = 1'b0; rr[d] = 1'b1;
      @(posedge clk); #1;
      rr[d] = 1'b0;
      chk({tag, " after handshake"}, {30'd0, rv[d], sr[d]}, 32'b01);
   endtask

   task automatic check_zero_outputs(input string tag);
      for (int d = 0; d < 3; d++) begin
         chk({tag, " valid/ready"}, {30'd0, rv[d], sr[d]}, 32'd0);
         chk({tag, " result+flags"}, {12'd0, flags_of(d), res_of(d)}, 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         sv[d] = 0; rr[d] = 0; sb[d] = 0; oa[d] = '0; ob[d] = '0;
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) chk("ready after reset", 32'(sr[d]), 32'd1);

      // Directed boundary vectors and random operations on every geometry
      for (int d = 0; d < 3; d++) begin
         run_op(d, 16'h1234, 16'h0FFF, 1'b0, 0, "add basic");
         run_op(d, 16'h0005, 16'h0007, 1'b1, 0, "sub borrow");
         run_op(d, 16'h7FFF, 16'h0001, 1'b0, 0, "add ovf");
         run_op(d, 16'h8000, 16'h0001, 1'b1, 0, "sub ovf");
         run_op(d, 16'hABCD, 16'hABCD, 1'b1, 0, "sub zero");
         run_op(d, 16'hFFFF, 16'h0001, 1'b0, 0, "add wrap");
         run_op(d, 16'h0080, 16'h0001, 1'b1, 0, "sub ovf8");
         run_op(d, 16'h007F, 16'h0001, 1'b0, 0, "add ovf8");
         for (int k = 0; k < 12; k++)
            run_op(d, 16'($urandom), 16'($urandom), 1'($urandom), k % 3, "random");
      end

      // Backpressure: result held while res_ready is low
      run_op(0, 16'h0005, 16'h0007, 1'b1, 5, "backpressure");
      run_op(0, 16'h1234, 16'h0FFF, 1'b0, 0, "after backpressure");
      run_op(0, 16'h0005, 16'h0007, 1'b1, 0, "pre-reset");

      // Reset two clocks into RUN aborts the operation
      @(negedge clk);
      oa[0] = 16'h1111; ob[0] = 16'h2222; sb[0] = 1'b0; sv[0] = 1'b1;
      @(posedge clk); #1;
      sv[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("async reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) chk("ready after mid-run reset", 32'(sr[d]), 32'd1);
      run_op(0, 16'h0001, 16'h0001, 1'b0, 0, "post-reset add");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
